// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth and pointer-width helpers plus the status
// bundle that both this synchronous controller and later async FIFOs decode.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;

  // Number of entries addressed by an address of width aw.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Pointers carry one extra wrap bit above the address.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: ADDR_WIDTH address bits plus one MSB that toggles
// each time the address rolls over, so equal addresses can be told apart as
// either full or empty. clr wins over inc.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_WIDTH:0] ptr
);

  logic [ADDR_WIDTH:0] ptr_d;
  logic [ADDR_WIDTH:0] ptr_q;

  // Next pointer: clear to zero, else step by one modulo 2**(ADDR_WIDTH+1).
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving one dual-port RAM as a circular buffer.
// Data never passes through this block; it only produces RAM control, status
// and the rd_valid qualifier for the RAM's registered dout.
//
// Request/accept semantics: wr_en and rd_en are requests sampled on the rising
// clk edge. A write is accepted when wr_en is high, the FIFO is not full and no
// flush is requested; a read is accepted when rd_en is high, the FIFO is not
// empty and no flush is requested. A rejected write or read raises overflow or
// underflow for the cycle after the edge (except under flush, which silently
// discards both). An accepted read makes rd_valid high for exactly the next
// cycle, when RAM dout holds the popped word.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              PTR_W   = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(depth_of(ADDR_WIDTH));
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             wr_acc;
  logic             rd_acc;

  logic [PTR_W-1:0] count_d,     count_q;
  logic             rd_valid_d,  rd_valid_q;
  logic             overflow_d,  overflow_q;
  logic             underflow_d, underflow_q;

  fifo_status_t     status;

  // Status decoded straight from the registered occupancy, no added latency.
  always_comb begin
    status              = '0;
    status.full         = (count_q == DEPTH_C);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AF_C);
    status.almost_empty = (count_q <= AE_C);
  end

  // Accept decisions; flush overrides both requests.
  always_comb begin
    wr_acc = wr_en & ~status.full  & ~flush;
    rd_acc = rd_en & ~status.empty & ~flush;
  end

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

  // Next occupancy, read-valid and error pulses.
  always_comb begin
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d     = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc}
                            - {{ADDR_WIDTH{1'b0}}, rd_acc};
      rd_valid_d  = rd_acc;
      overflow_d  = wr_en & status.full;
      underflow_d = rd_en & status.empty;
    end
  end

  // Occupancy and one-cycle indicator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_we       = wr_acc;
  assign ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // The pointer pair and the occupancy counter are redundant views of the
  // same state; they must always tell the same story.
  logic ptr_full;
  logic ptr_empty;
  assign ptr_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign ptr_empty = (wr_ptr == rd_ptr);

  a_full_agrees: assert property (@(posedge clk) disable iff (!rst_n)
    status.full == ptr_full);
  a_empty_agrees: assert property (@(posedge clk) disable iff (!rst_n)
    status.empty == ptr_empty);
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);
  a_count_diff: assert property (@(posedge clk) disable iff (!rst_n)
    count_q == (wr_ptr - rd_ptr));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a behavioural RAM, a queue-based FIFO model that
// is checked against every output on every cycle, and directed vectors with
// hand-computed literal expectations.
module tb_sync_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    din   = 8'h00;

  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [AW-1:0] ram_rd_addr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .flush        (flush),
    .ram_we       (ram_we),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_addr  (ram_rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Behavioural dual-port RAM with registered read, both ports on clk.
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= din;
    ram_dout <= mem[ram_rd_addr];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  // Contents as a queue; addresses as write/read counts modulo DEPTH.
  logic [7:0] exp_q [$];
  int         m_wa     = 0;
  int         m_ra     = 0;
  logic       m_rv     = 1'b0;
  logic       m_ovf    = 1'b0;
  logic       m_unf    = 1'b0;
  logic [7:0] m_rdata  = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_wa  <= 0;
      m_ra  <= 0;
      m_rv  <= 1'b0;
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_wa  <= 0;
      m_ra  <= 0;
      m_rv  <= 1'b0;
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else begin
      m_ovf <= wr_en && (exp_q.size() == DEPTH);
      m_unf <= rd_en && (exp_q.size() == 0);
      m_rv  <= rd_en && (exp_q.size() > 0);
      if (rd_en && exp_q.size() > 0) begin
        m_rdata <= exp_q[0];
        m_ra    <= (m_ra + 1) % DEPTH;
      end
      if (wr_en && exp_q.size() < DEPTH) begin
        m_wa <= (m_wa + 1) % DEPTH;
      end
      // Pop before push so the queue reflects the pre-edge occupancy above.
      if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (wr_en && (exp_q.size() < DEPTH || (rd_en && exp_q.size() == DEPTH - 1 + 1 && 1'b0)))
        exp_q.push_back(din);
    end
  end

  // Compare process: every output against the model, once per cycle.
  always @(negedge clk) begin
    #1;
    check("ram_we",       32'(ram_we),       32'(wr_en && !flush && exp_q.size() < DEPTH));
    check("ram_wr_addr",  32'(ram_wr_addr),  32'(m_wa));
    check("ram_rd_addr",  32'(ram_rd_addr),  32'(m_ra));
    check("count",        32'(count),        32'(exp_q.size()));
    check("full",         32'(full),         32'(exp_q.size() == DEPTH));
    check("empty",        32'(empty),        32'(exp_q.size() == 0));
    check("almost_full",  32'(almost_full),  32'(exp_q.size() >= 14));
    check("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= 2));
    check("rd_valid",     32'(rd_valid),     32'(m_rv));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    if (m_rv) check("rd_data", 32'(ram_dout), 32'(m_rdata));
  end

  // ---------------- driver ----------------
  // Drive one cycle of requests, then return just after the edge that took them.
  task automatic step(input logic w, input logic r, input logic f,
                      input logic [7:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    flush = f;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle.
    idle();
    check("rst_empty",  32'(empty),        32'd1);
    check("rst_ae",     32'(almost_empty), 32'd1);
    check("rst_full",   32'(full),         32'd0);
    check("rst_af",     32'(almost_full),  32'd0);
    check("rst_count",  32'(count),        32'd0);
    check("rst_we",     32'(ram_we),       32'd0);
    check("rst_ovf",    32'(overflow),     32'd0);
    check("rst_unf",    32'(underflow),    32'd0);
    check("rst_rv",     32'(rd_valid),     32'd0);

    // Two writes, two reads.
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    check("w1_addr",  32'(ram_wr_addr), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'hBB);
    check("w2_count", 32'(count), 32'd2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("r1_valid", 32'(rd_valid), 32'd1);
    check("r1_data",  32'(ram_dout), 32'hAA);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("r2_valid", 32'(rd_valid), 32'd1);
    check("r2_data",  32'(ram_dout), 32'hBB);
    check("r2_count", 32'(count),    32'd0);
    idle();
    check("r_done_valid", 32'(rd_valid), 32'd0);

    // Fill to full, flag thresholds, then one write too many.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      check("fill_af",   32'(almost_full), 32'(i >= 13));
      check("fill_full", 32'(full),        32'(i == 15));
    end
    check("fill_count", 32'(count), 32'd16);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
    idle();
    check("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("drain_data", 32'(ram_dout), 32'(8'h10 + i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Read on empty with a write in the same cycle.
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    check("unf_pulse", 32'(underflow), 32'd1);
    check("unf_count", 32'(count),     32'd1);
    check("unf_rv",    32'(rd_valid),  32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("unf_rd_valid", 32'(rd_valid), 32'd1);
    check("unf_rd_data",  32'(ram_dout), 32'h5A);

    // Steady state at count 8 with simultaneous read and write across the wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
      check("rw_count", 32'(count), 32'd8);
    end
    check("rw_wr_addr", 32'(ram_wr_addr), 32'd15);
    check("rw_rd_addr", 32'(ram_rd_addr), 32'd7);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("rw_tail", 32'(ram_dout), 32'(8'h40 + 12 + i));
    end

    // Flush at count 5 with both requests high.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check("fl_count", 32'(count),       32'd0);
    check("fl_empty", 32'(empty),       32'd1);
    check("fl_ovf",   32'(overflow),    32'd0);
    check("fl_unf",   32'(underflow),   32'd0);
    check("fl_rv",    32'(rd_valid),    32'd0);
    check("fl_wa",    32'(ram_wr_addr), 32'd0);
    check("fl_ra",    32'(ram_rd_addr), 32'd0);

    // Reset in the middle of a write burst.
    step(1'b1, 1'b0, 1'b0, 8'h81);
    step(1'b1, 1'b1, 1'b0, 8'h82);
    step(1'b1, 1'b1, 1'b0, 8'h83);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_count", 32'(count),       32'd0);
    check("mr_empty", 32'(empty),       32'd1);
    check("mr_ae",    32'(almost_empty),32'd1);
    check("mr_full",  32'(full),        32'd0);
    check("mr_rv",    32'(rd_valid),    32'd0);
    check("mr_ovf",   32'(overflow),    32'd0);
    check("mr_unf",   32'(underflow),   32'd0);
    check("mr_wa",    32'(ram_wr_addr), 32'd0);
    check("mr_ra",    32'(ram_rd_addr), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Traffic after reset release.
    step(1'b1, 1'b0, 1'b0, 8'h9C);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("post_data", 32'(ram_dout), 32'h9C);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences one dual_port_ram instance as a circular buffer. Both RAM clocks are tied to clk at the parent.
- Drives RAM write enable, write address and read address.
- Reports occupancy and status flags.
- Flags data on the RAM dout as valid.
- Data (din/dout) connects RAM-to-user directly; this block handles control only.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
clk  in  1  single system clock, rising edge; also drives RAM wr_clk and rd_clk.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  user write request; data on RAM din this cycle.
rd_en  in  1  user read request.
flush  in  1  synchronous clear of FIFO contents.
ram_we  out  1  to RAM we.
ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
rd_valid  out  1  RAM dout holds the popped word this cycle.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  one-cycle pulse: write rejected.
underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
Reset (rst_n low, asynchronous):
- wr_ptr, rd_ptr, count, rd_valid, overflow and underflow all go to 0.
- Status outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0.

Pointers:
- wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is a wrap bit.
- ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0] and ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0], both combinational.
- Pointers increment modulo 2**(ADDR_WIDTH+1); the address wraps 15 -> 0.

Accept conditions:
- wr_acc = wr_en & ~full & ~flush. ram_we = wr_acc (combinational).
- rd_acc = rd_en & ~empty & ~flush.

Read latency:
- The RAM registers dout on its clock edge. On the edge that accepts a read, dout captures mem[rd_ptr] and rd_ptr increments.
- rd_valid is registered as rd_acc and is high for exactly the following cycle. Read latency is 1 cycle.

count:
- Next count = count + wr_acc - rd_acc.
- Simultaneous accepted read and write leave count unchanged.

Flags:
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count; no extra latency.

Boundaries:
- Write while full: rejected, no RAM write, overflow pulses the next cycle. A read in the same cycle still proceeds. There is no write-through on full.
- Read while empty: rejected, rd_valid=0, underflow pulses the next cycle. A write in the same cycle still proceeds. There is no bypass, so data written into an empty FIFO is readable no earlier than the next cycle.
- Wrap: full when the pointer addresses are equal and the MSBs differ; empty when the pointers are fully equal. Both must agree with count; a mismatch is an assertion failure.

flush:
- At the next edge, wr_ptr = rd_ptr = 0 and count = 0. rd_valid, overflow and underflow are 0.
- wr_en and rd_en in the flush cycle are ignored and raise no error pulse.
- flush takes priority over all requests.

Reset mid-operation:
- All state clears immediately. RAM contents are not cleared and become unreachable.

Decomposition:
- Shared package fifo_pkg holds: DEPTH function/constant derived from ADDR_WIDTH, pointer width constant ADDR_WIDTH+1, and a status struct-like bundle (full, empty, almost_full, almost_empty) reused by future async FIFO work.
- One natural sub-module: fifo_ptr. It is a wrap-bit pointer register with inc and clr inputs and async active-low reset, instantiated twice (write side and read side).

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, ram_we=0, all pulses 0.
- Write 0xAA then 0xBB (addresses 0, 1), then read twice -> rd_valid high 1 cycle after each accepted read; RAM dout = 0xAA then 0xBB; count returns 0.
- 16 consecutive writes -> almost_full asserts at count=14, full at 16. 17th write -> ram_we=0, overflow pulse, count stays 16.
- Read on empty with simultaneous write -> underflow pulse, count=1. Read on the next cycle -> rd_valid with the written data.
- Fill, drain and refill past address 15 with simultaneous read/write at count=8 for 20 cycles -> count stays 8, addresses wrap 15->0, data order preserved.
- flush at count=5 with wr_en=rd_en=1 -> next cycle count=0, empty=1, no ram_we, no overflow/underflow. Then assert rst_n low mid-burst -> all outputs at reset values immediately.
